// File: rtl/bitwise_result_serializer.sv
// bitwise_result_serializer
//
// Downstream stage of the bitwise operation unit. Each {AND, OR, XOR}
// result triple the unit produces is buffered in a small FIFO. The triple
// then leaves as three consecutive tagged words on a valid/ready stream,
// so a single narrow consumer can take the results.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a result triple is present on in_and/in_or/in_xor
//   in_ready   the FIFO can accept a triple this cycle
//   in_and     a & b result
//   in_or      a | b result
//   in_xor     a ^ b result
//   out_valid  out_data/out_sel/out_last are valid
//   out_ready  the consumer accepts the current word
//   out_data   current result word
//   out_sel    word tag: 0=AND, 1=OR, 2=XOR
//   out_last   high on the XOR word, the last word of its triple
//   level      triples stored, including the one being sent

module bitwise_result_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_and,
    input  logic [WIDTH-1:0]         in_or,
    input  logic [WIDTH-1:0]         in_xor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_sel,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_AND = 2'd0,
        S_OR  = 2'd1,
        S_XOR = 2'd2
    } phase_t;

    phase_t             phase;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic [WIDTH-1:0]   mem_and [DEPTH];
    logic [WIDTH-1:0]   mem_or  [DEPTH];
    logic [WIDTH-1:0]   mem_xor [DEPTH];

    logic push;
    logic beat;
    logic pop;

    // Handshake flags come only from registered level, so there is no
    // combinational path from in_valid to out_valid or out_ready to in_ready.
    // When full, in_ready stays low even if the head triple is popped this cycle.
    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);

    assign push = in_valid && in_ready;
    assign beat = out_valid && out_ready;
    assign pop  = beat && (phase == S_XOR);

    // Triple storage; contents are never observable while the FIFO is empty,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_and[wr_ptr] <= in_and;
            mem_or[wr_ptr]  <= in_or;
            mem_xor[wr_ptr] <= in_xor;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Word phase of the head triple. It advances only on a beat, so the word
    // is held steady under backpressure. The XOR beat pops the triple and
    // returns to S_AND, so an empty FIFO always sits in S_AND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= S_AND;
        end else if (beat) begin
            case (phase)
                S_AND:   phase <= S_OR;
                S_OR:    phase <= S_XOR;
                S_XOR:   phase <= S_AND;
                default: phase <= S_AND;
            endcase
        end
    end

    // Output word selection from the head slot. Everything is forced to zero
    // while empty so the stream looks idle.
    always_comb begin
        out_data = '0;
        out_sel  = 2'd0;
        out_last = 1'b0;
        if (out_valid) begin
            case (phase)
                S_AND: begin
                    out_data = mem_and[rd_ptr];
                    out_sel  = 2'd0;
                end
                S_OR: begin
                    out_data = mem_or[rd_ptr];
                    out_sel  = 2'd1;
                end
                S_XOR: begin
                    out_data = mem_xor[rd_ptr];
                    out_sel  = 2'd2;
                    out_last = 1'b1;
                end
                default: begin
                    out_data = '0;
                    out_sel  = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_result_serializer.sv
// Testbench for bitwise_result_serializer.
// Table vectors, hand-written corner sequences and a randomized stream are
// all checked against a queue-of-triples reference model.

module tb_bitwise_result_serializer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_and;
    logic [WIDTH-1:0]   in_or;
    logic [WIDTH-1:0]   in_xor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_last;
    logic [2:0]         level;

    bitwise_result_serializer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_and(in_and),
        .in_or(in_or),
        .in_xor(in_xor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sel(out_sel),
        .out_last(out_last),
        .level(level)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] x;
    } triple_t;

    typedef struct {
        logic [WIDTH-1:0] in_and;
        logic [WIDTH-1:0] in_or;
        logic [WIDTH-1:0] in_xor;
        logic [WIDTH-1:0] exp_word [3];
    } vec_t;

    // Reference model: the stored triples in push order, plus which of the
    // head's three words is next.
    triple_t model_q[$];
    int      word_idx;
    logic    last_push;

    int n_checks;
    int n_fail;

    // Shared comparison and failure report.
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input triple_t t, input int i);
        case (i)
            0:       return t.a;
            1:       return t.o;
            default: return t.x;
        endcase
    endfunction

    // Drive the input side and the consumer's ready.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] x,
                                 input logic rdy);
        in_valid  = v;
        in_and    = a;
        in_or     = o;
        in_xor    = x;
        out_ready = rdy;
    endtask

    // Compare every DUT output with what the model says it should be now.
    task automatic checkOutput();
        int  n;
        logic ev;
        n  = model_q.size();
        ev = (n != 0);
        compare("out_valid", out_valid, ev);
        compare("in_ready", in_ready, n != DEPTH);
        compare("level", level, n);
        compare("out_data", out_data, ev ? word_of(model_q[0], word_idx) : '0);
        compare("out_sel", out_sel, ev ? word_idx : 0);
        compare("out_last", out_last, ev && word_idx == 2);
    endtask

    // Check, clock one edge, then advance the model by the handshakes the
    // edge should have seen.
    task automatic tick();
        logic    push;
        logic    beat;
        triple_t t;
        checkOutput();
        push = in_valid && (model_q.size() < DEPTH);
        beat = out_ready && (model_q.size() > 0);
        t = '{a: in_and, o: in_or, x: in_xor};
        @(posedge clk);
        #1;
        if (beat) begin
            if (word_idx == 2) begin
                void'(model_q.pop_front());
                word_idx = 0;
            end else begin
                word_idx++;
            end
        end
        if (push) model_q.push_back(t);
        last_push = push;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            tick();
        end
    endtask

    vec_t vecs [4];

    initial begin
        int      pending;
        int      rise_c;
        int      pushed;
        logic    done;
        triple_t t;

        n_checks = 0;
        n_fail   = 0;
        word_idx = 0;
        last_push = 1'b0;

        vecs[0] = '{16'h0F00, 16'hFFF0, 16'hF0F0, '{16'h0F00, 16'hFFF0, 16'hF0F0}};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, '{16'h0000, 16'hFFFF, 16'hFFFF}};
        vecs[2] = '{16'h1234, 16'h5678, 16'h444C, '{16'h1234, 16'h5678, 16'h444C}};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, '{16'hA5A5, 16'h5A5A, 16'hFFFF}};

        // Reset values
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        #12;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Table vectors: single triple into an empty FIFO, out_ready high
        for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b1, vecs[v].in_and, vecs[v].in_or, vecs[v].in_xor, 1'b1);
            tick();
            applyStimulus(1'b0, '0, '0, '0, 1'b1);
            for (int w = 0; w < 3; w++) begin
                compare("vec_word", out_data, vecs[v].exp_word[w]);
                compare("vec_sel", out_sel, w);
                compare("vec_last", out_last, w == 2);
                tick();
            end
            compare("vec_empty_valid", out_valid, 1'b0);
            compare("vec_empty_level", level, 0);
        end

        // Fill to full with the consumer stalled; the 5th triple is held
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 1'b0);
            tick();
            if (i == 3) begin
                compare("fill_level", level, 4);
                compare("fill_in_ready", in_ready, 1'b0);
            end
        end
        pending = 1;
        rise_c  = -1;
        for (int c = 0; c < 40 && (pending != 0 || model_q.size() != 0); c++) begin
            if (rise_c < 0 && in_ready) rise_c = c;
            applyStimulus(pending != 0, 16'h1004, 16'h2004, 16'h3004, 1'b1);
            tick();
            if (last_push) pending = 0;
        end
        compare("fill_ready_rise_cycle", rise_c, 3);
        idle(1);

        // Backpressure while the OR word is presented
        applyStimulus(1'b1, 16'hBEEF, 16'hCAFE, 16'h7411, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0);
            compare("bp_frozen_data", out_data, 16'hCAFE);
            compare("bp_frozen_sel", out_sel, 1);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        compare("bp_resume_data", out_data, 16'hCAFE);
        tick();
        compare("bp_xor_data", out_data, 16'h7411);
        compare("bp_xor_sel", out_sel, 2);
        idle(2);

        // Push on the same cycle as the S_XOR beat with level 2
        applyStimulus(1'b1, 16'h0101, 16'h0202, 16'h0303, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0404, 16'h0505, 16'h0606, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 16'h0707, 16'h0808, 16'h0909, 1'b1);
        compare("pp_pre_last", out_last, 1'b1);
        tick();
        compare("pp_level", level, 2);
        compare("pp_next_sel", out_sel, 0);
        compare("pp_next_data", out_data, 16'h0404);
        idle(7);

        // Randomized stream of 10 triples with 50% consumer ready
        pushed = 0;
        done   = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            t = '{a: 16'($urandom), o: 16'($urandom), x: 16'($urandom)};
            applyStimulus((pushed < 10) ? 1'($urandom_range(0, 1)) : 1'b0,
                          t.a, t.o, t.x, 1'($urandom_range(0, 1)));
            tick();
            if (last_push) pushed++;
            if (pushed == 10 && model_q.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL random_stream_timeout: actual pushed=%0d left=%0d required pushed=10 left=0",
                     pushed, model_q.size());
        end
        idle(1);

        // Asynchronous reset between edges while in S_OR with level 3
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hD000 + 16'(i), 16'hE000 + 16'(i), 16'hF000 + 16'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        tick();
        compare("rst_pre_sel", out_sel, 1);
        compare("rst_pre_level", level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        compare("rst_out_valid", out_valid, 1'b0);
        compare("rst_out_sel", out_sel, 0);
        compare("rst_out_data", out_data, 0);
        compare("rst_level", level, 0);
        compare("rst_in_ready", in_ready, 1'b1);
        model_q.delete();
        word_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h5555, 16'h6666, 16'h3333, 1'b1);
        tick();
        compare("post_rst_sel", out_sel, 0);
        compare("post_rst_data", out_data, 16'h5555);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_result_serializer.md
# bitwise_result_serializer

- Downstream stage of the bitwise operation unit: captures each {AND, OR, XOR} result triple the unit produces and buffers it in a small FIFO.
- Drives the triple out as three consecutive tagged 16-bit words over a valid/ready stream, so a single narrow consumer (bus writer, display, checker) can take the results.
- Absorbs bursts from the operation unit and applies backpressure when the buffer is full.

## Interface

Parameters:
- WIDTH, 16, width of each result word
- DEPTH, 4, FIFO depth in triples; power of two, ≥2

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  result triple present on in_and/in_or/in_xor
- in_ready  output  1  FIFO can accept a triple this cycle
- in_and  input  WIDTH  a & b result
- in_or  input  WIDTH  a | b result
- in_xor  input  WIDTH  a ^ b result
- out_valid  output  1  out_data/out_sel/out_last valid
- out_ready  input  1  consumer accepts the current word
- out_data  output  WIDTH  current result word
- out_sel  output  2  word tag: 0=AND, 1=OR, 2=XOR (3 never driven)
- out_last  output  1  high when the current word is the XOR word, i.e. the last of its triple
- level  output  $clog2(DEPTH)+1  number of triples stored, including the one being sent

## Operation

Handshakes:
- An input push occurs when in_valid && in_ready.
- An output beat occurs when out_valid && out_ready.

FIFO:
- Stores {in_and, in_or, in_xor} at the write pointer on a push.
- Pointers wrap modulo DEPTH.
- level increments on a push and decrements on a pop, and is unchanged when both happen in the same cycle.
- in_ready = (level != DEPTH), decoded combinationally from registered level.
- When full, in_ready stays low even if a pop occurs that cycle. There is no full-bypass; the next push is accepted one cycle later.

Serializer state machine (phase register):
- S_AND:
  - out_sel=0, out_data=head.and.
  - On a beat, go to S_OR.
- S_OR:
  - out_sel=1, out_data=head.or.
  - On a beat, go to S_XOR.
- S_XOR:
  - out_sel=2, out_data=head.xor, out_last=1.
  - On a beat, pop the head triple and return to S_AND.
- With no beat, the phase holds, and out_data/out_sel are stable while out_valid && !out_ready.
- out_valid = (level != 0).
- When level == 0: phase is S_AND, out_data=0, out_sel=0, out_last=0.

Reset:
- Reset clears level and both pointers and forces phase to S_AND.
- Output values after reset: out_valid=0, out_data=0, out_sel=0, out_last=0, level=0, in_ready=1.
- Reset asserted mid-triple discards the partial triple and all stored triples; there is no replay.
- FIFO storage contents are not reset and are unobservable while empty.

## Timing

- Latency: a triple pushed at edge k gives out_valid=1 with its AND word after edge k (cycle k+1), when the FIFO was empty.
- Throughput: one word per cycle with out_ready held high, i.e. one triple per 3 cycles. The input can sustain one push per 3 cycles without filling.
- Push into an empty FIFO and a beat in the same cycle cannot occur, because out_valid is low when empty.
- Simultaneous push and S_XOR pop: level unchanged, the next triple's AND word is presented in the following cycle, and there are no bubbles.
- in_ready and out_valid are decoded only from registers; there is no combinational path from in_valid to out_valid or from out_ready to in_ready.
- Reset deassertion: the first push is accepted at the first rising edge with rst_n high.

## Test plan

- Single triple, out_ready=1:
  - Stimulus: push AND=0x0F00, OR=0xFFF0, XOR=0xF0F0.
  - Required: words 0x0F00/sel0, 0xFFF0/sel1, 0xF0F0/sel2 with last=1 on cycles k+1..k+3, then out_valid=0 and level=0.
- Fill to full, out_ready=0:
  - Stimulus: push 5 triples back-to-back.
  - Required: first 4 accepted, in_ready=0 after the 4th, level=4, 5th held by the source.
  - Then release out_ready: 12 words in push order, and in_ready rises the cycle after the first S_XOR pop.
- Backpressure mid-triple:
  - Stimulus: drop out_ready for 3 cycles while in S_OR.
  - Required: out_data/out_sel frozen at the OR word, then resume at S_XOR with no word lost or duplicated.
- Simultaneous push and pop:
  - Stimulus: with level=2, push on the same cycle as the S_XOR beat.
  - Required: level stays 2, and the next AND word appears on the following cycle.
- Pointer wrap:
  - Stimulus: stream 10 triples with random values and random out_ready (50%).
  - Required: output sequence matches the scoreboard exactly, including across the wrap of both pointers.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges while in S_OR with level=3.
  - Required: immediately out_valid=0, out_sel=0, level=0, in_ready=1; after release, a new push emits its AND word first.
